// File: rtl/count_mod_updown.sv
// Modulo-N up/down counter with load, wrap/saturate mode and cascade flags.
// tc is combinational so a chained stage steps on this stage's wrap/limit edge.
module count_mod_updown #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             sat
);

  localparam longint unsigned MAXMOD =
    64'd1 << WIDTH;

  if (MODULUS < 2 ||
      longint'(MODULUS) > MAXMOD) begin : g_bad_mod
    $error("MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] count_nxt;
  logic             at_term;
  logic             wrapped_nxt;
  logic             sat_nxt;

  // Terminal value follows direction; tc masked by reset and load.
  always_comb begin
    term       = up ? LAST : '0;
    at_term    = (count == term);
    tc         = en & ~load & ~rst & at_term;
    load_clamp = (load_val > LAST) ? LAST
                                   : load_val;
  end

  // Next-state selection: load beats count, enabled step wraps or holds.
  always_comb begin
    count_nxt   = count;
    wrapped_nxt = 1'b0;
    sat_nxt     = sat;
    unique case (1'b1)
      load: begin
        count_nxt = load_clamp;
        sat_nxt   = 1'b0;
      end
      (~load & en & at_term): begin
        if (SATURATE) begin
          sat_nxt = 1'b1;
        end else begin
          count_nxt   = up ? '0 : LAST;
          wrapped_nxt = 1'b1;
          sat_nxt     = 1'b0;
        end
      end
      (~load & en & ~at_term): begin
        count_nxt = up ? count + WIDTH'(1)
                       : count - WIDTH'(1);
        sat_nxt   = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wrapped <= 1'b0;
      sat     <= 1'b0;
    end else begin
      count   <= count_nxt;
      wrapped <= wrapped_nxt;
      sat     <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_count_mod_updown.sv
// Bench for count_mod_updown: wrap, saturate and full-range instances
// plus a two-stage cascade, against a behavioural arithmetic model.
module tb_count_mod_updown;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [3:0] cnt [3];
  logic       tcv [3];
  logic       wrv [3];
  logic       satv[3];

  logic       en_c, up_c, load_c;
  logic [3:0] lv_c;
  logic [3:0] cnt_lo, cnt_hi;
  logic       tc_lo, tc_hi, wr_lo, wr_hi;
  logic       sat_lo, sat_hi;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 wrap M=10, 1 saturate M=10, 2 wrap M=16
  int mc[3];
  bit mw[3];
  bit ms[3];
  int mm[3] = '{10, 10, 16};
  bit msm[3] = '{1'b0, 1'b1, 1'b0};
  int mcl, mch;
  bit mwl, mwh, msl, msh;

  count_mod_updown #(.WIDTH(4), .MODULUS(10),
                     .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tcv[0]),
    .wrapped(wrv[0]), .sat(satv[0]));

  count_mod_updown #(.WIDTH(4), .MODULUS(10),
                     .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tcv[1]),
    .wrapped(wrv[1]), .sat(satv[1]));

  count_mod_updown #(.WIDTH(4), .MODULUS(16),
                     .SATURATE(1'b0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tcv[2]),
    .wrapped(wrv[2]), .sat(satv[2]));

  count_mod_updown #(.WIDTH(4), .MODULUS(10),
                     .SATURATE(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c),
    .load(load_c), .load_val(lv_c),
    .count(cnt_lo), .tc(tc_lo),
    .wrapped(wr_lo), .sat(sat_lo));

  count_mod_updown #(.WIDTH(4), .MODULUS(10),
                     .SATURATE(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up(up_c),
    .load(load_c), .load_val(lv_c),
    .count(cnt_hi), .tc(tc_hi),
    .wrapped(wr_hi), .sat(sat_hi));

  task automatic mstep(input int m, input bit sm,
                       input bit r, input bit l,
                       input bit e, input bit u,
                       input int lv, inout int c,
                       inout bit w, inout bit s);
    int lim;
    lim = u ? m - 1 : 0;
    if (r) begin
      c = 0; w = 0; s = 0;
    end else if (l) begin
      c = (lv > m - 1) ? m - 1 : lv;
      w = 0; s = 0;
    end else if (e) begin
      if (c == lim && sm) begin
        s = 1; w = 0;
      end else begin
        w = (c == lim);
        c = (c + (u ? 1 : m - 1)) % m;
        s = 0;
      end
    end else begin
      w = 0;
    end
  endtask

  function automatic bit mtc(input int m, input int c,
                             input bit r, input bit l,
                             input bit e, input bit u);
    return !r && !l && e && (c == (u ? m - 1 : 0));
  endfunction

  task automatic tick();
    bit tl;
    tl = mtc(10, mcl, rst, load_c, en_c, up_c);
    for (int k = 0; k < 3; k++)
      mstep(mm[k], msm[k], rst, load, en, up,
            int'(load_val), mc[k], mw[k], ms[k]);
    mstep(10, 1'b0, rst, load_c, en_c, up_c,
          int'(lv_c), mcl, mwl, msl);
    mstep(10, 1'b0, rst, load_c, tl, up_c,
          int'(lv_c), mch, mwh, msh);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit l,
                       input bit e, input bit u,
                       input logic [3:0] lv);
    rst = r; load = l; en = e; up = u;
    load_val = lv;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    en_c = 1'b1; up_c = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cnt[k] !== 4'd0 || wrv[k] !== 1'b0 ||
          satv[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: cnt=%0d wr=%b sat=%b want 0 0 0",
                 k, cnt[k], wrv[k], satv[k]);
      end
    end
    #1;
    n_checks++;
    if (tcv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tc: tc=%b want 0", tcv[0]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    en_c = 1'b0; up_c = 1'b1;
    tick();
  endtask

  task automatic test_wrap_up();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (tcv[0] !== (i % 10 == 9)) begin
        n_fail++;
        $display("FAIL up_tc step %0d: tc=%b want %b",
                 i, tcv[0], (i % 10 == 9));
      end
      tick();
      n_checks++;
      if (cnt[0] !== 4'((i + 1) % 10) ||
          wrv[0] !== (i % 10 == 9)) begin
        n_fail++;
        $display("FAIL up_cnt step %0d: cnt=%0d wr=%b want %0d %b",
                 i, cnt[0], wrv[0], (i + 1) % 10,
                 (i % 10 == 9));
      end
    end
  endtask

  task automatic test_wrap_down();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    n_checks++;
    if (tcv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL down_tc: tc=%b want 1", tcv[0]);
    end
    tick();
    n_checks++;
    if (cnt[0] !== 4'd9 || wrv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: cnt=%0d wr=%b want 9 1",
               cnt[0], wrv[0]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    n_checks++;
    if (cnt[0] !== 4'd9 || wrv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_hold: cnt=%0d wr=%b want 9 0",
               cnt[0], wrv[0]);
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    tick();
    n_checks++;
    if (cnt[0] !== 4'd7 || cnt[2] !== 4'd7) begin
      n_fail++;
      $display("FAIL load7: cnt=%0d/%0d want 7/7",
               cnt[0], cnt[2]);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd13);
    #1;
    n_checks++;
    if (tcv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_tc: tc=%b want 0", tcv[0]);
    end
    tick();
    n_checks++;
    if (cnt[0] !== 4'd9 || cnt[2] !== 4'd13 ||
        wrv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load13: cnt=%0d/%0d wr=%b want 9/13 0",
               cnt[0], cnt[2], wrv[0]);
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (tcv[1] !== (i > 0)) begin
        n_fail++;
        $display("FAIL sat_tc step %0d: tc=%b want %b",
                 i, tcv[1], (i > 0));
      end
      tick();
      n_checks++;
      if (cnt[1] !== 4'd9 || satv[1] !== (i > 0) ||
          wrv[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_cnt step %0d: cnt=%0d sat=%b wr=%b want 9 %b 0",
                 i, cnt[1], satv[1], wrv[1], (i > 0));
      end
    end
    up = 1'b0;
    #1;
    n_checks++;
    if (tcv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_rev_tc: tc=%b want 0", tcv[1]);
    end
    tick();
    n_checks++;
    if (cnt[1] !== 4'd8 || satv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_rev: cnt=%0d sat=%b want 8 0",
               cnt[1], satv[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) == 0,
            ($urandom % 8) == 0,
            ($urandom % 4) != 0,
            ($urandom % 3) != 0,
            4'($urandom));
      #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (tcv[k] !== mtc(mm[k], mc[k], rst, load,
                           en, up)) begin
          n_fail++;
          $display("FAIL rnd_tc[%0d] cyc %0d: tc=%b want %b",
                   k, i, tcv[k],
                   mtc(mm[k], mc[k], rst, load, en, up));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (cnt[k] !== 4'(mc[k]) || wrv[k] !== mw[k] ||
            satv[k] !== ms[k]) begin
          n_fail++;
          $display("FAIL rnd[%0d] cyc %0d: cnt=%0d wr=%b sat=%b want %0d %b %b",
                   k, i, cnt[k], wrv[k], satv[k],
                   mc[k], mw[k], ms[k]);
        end
      end
    end
  endtask

  task automatic test_cascade();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    en_c = 1'b1; up_c = 1'b1;
    for (int i = 0; i < 99; i++) begin
      #1;
      n_checks++;
      if (tc_lo !== mtc(10, mcl, rst, load_c,
                        en_c, up_c)) begin
        n_fail++;
        $display("FAIL casc_tc cyc %0d: tc=%b want %b",
                 i, tc_lo,
                 mtc(10, mcl, rst, load_c, en_c, up_c));
      end
      tick();
      n_checks++;
      if (cnt_lo !== 4'(mcl) || cnt_hi !== 4'(mch)) begin
        n_fail++;
        $display("FAIL casc cyc %0d: lo=%0d hi=%0d want %0d %0d",
                 i, cnt_lo, cnt_hi, mcl, mch);
      end
    end
    n_checks++;
    if (cnt_lo !== 4'd9 || cnt_hi !== 4'd9) begin
      n_fail++;
      $display("FAIL casc_99: lo=%0d hi=%0d want 9 9",
               cnt_lo, cnt_hi);
    end
    #1;
    n_checks++;
    if (tc_lo !== 1'b1 || tc_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL casc_tc99: tc lo=%b hi=%b want 1 1",
               tc_lo, tc_hi);
    end
    tick();
    n_checks++;
    if (cnt_lo !== 4'd0 || cnt_hi !== 4'd0 ||
        wr_lo !== 1'b1 || wr_hi !== 1'b1) begin
      n_fail++;
      $display("FAIL casc_wrap: lo=%0d hi=%0d wr=%b%b want 0 0 11",
               cnt_lo, cnt_hi, wr_lo, wr_hi);
    end
    en_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_c = 1'b0; lv_c = 4'd0;
    en_c = 1'b0; up_c = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      mc[k] = 0; mw[k] = 0; ms[k] = 0;
    end
    mcl = 0; mch = 0;
    mwl = 0; mwh = 0; msl = 0; msh = 0;
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load();
    test_saturate();
    test_random();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
